// File: rtl/fft_pkg.sv
// Shared constants, quarter-wave magnitude table and FSM state type for the
// 64-point FFT twiddle path.
package fft_pkg;

    localparam int N     = 64;
    localparam int LOG2N = 6;
    localparam int TW_W  = 12;

    localparam logic signed [TW_W-1:0] ONE = 12'sd256;

    // |cos(2*pi*m/64)| for m = 0..16 in Q4.8, floor-quantised
    localparam logic signed [TW_W-1:0] C_TAB [0:16] = '{
        12'sd256, 12'sd254, 12'sd251, 12'sd244, 12'sd236, 12'sd225,
        12'sd212, 12'sd197, 12'sd181, 12'sd162, 12'sd142, 12'sd120,
        12'sd97,  12'sd74,  12'sd49,  12'sd25,  12'sd0
    };

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Table-coded negation: one's complement, with -1.0 and -0 special-cased
    function automatic logic signed [TW_W-1:0] tw_neg(input logic signed [TW_W-1:0] x);
        if (x == ONE) begin
            return 12'shF00;
        end else if (x == '0) begin
            return '0;
        end
        return ~x;
    endfunction

endpackage

// File: rtl/tw_quarter_lut.sv
// Combinational twiddle lookup: folds k[5:0] into one quarter-wave table
// and applies table-coded negation per quadrant.
module tw_quarter_lut
    import fft_pkg::*;
(
    input  logic        [LOG2N-1:0] k,
    output logic signed [TW_W-1:0]  cos_w,
    output logic signed [TW_W-1:0]  sin_w
);

    logic [1:0]                q;
    logic [4:0]                m;
    logic [4:0]                m_c;
    logic signed [TW_W-1:0]    c_m;
    logic signed [TW_W-1:0]    c_mc;

    assign q    = k[5:4];
    assign m    = {1'b0, k[3:0]};
    assign m_c  = 5'd16 - m;
    assign c_m  = C_TAB[m];
    assign c_mc = C_TAB[m_c];

    // W^k = cos(theta) - j*sin(theta), theta = 2*pi*k/64, folded by quadrant
    always_comb begin
        cos_w = c_m;
        sin_w = tw_neg(c_mc);
        case (q)
            2'd0: begin
                cos_w = c_m;
                sin_w = tw_neg(c_mc);
            end
            2'd1: begin
                cos_w = tw_neg(c_mc);
                sin_w = tw_neg(c_m);
            end
            2'd2: begin
                cos_w = tw_neg(c_m);
                sin_w = c_mc;
            end
            default: begin
                cos_w = c_mc;
                sin_w = c_m;
            end
        endcase
    end

endmodule

// File: rtl/twiddle_streamer.sv
// Streams the 32 twiddle factors of one radix-2 FFT stage with a
// valid/ready handshake, holding the output beat while stalled.
module twiddle_streamer
    import fft_pkg::*;
(
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [2:0]              stage,
    input  logic                    out_ready,
    output logic                    tw_valid,
    output logic signed [TW_W-1:0]  tw_cos,
    output logic signed [TW_W-1:0]  tw_sin,
    output logic [LOG2N-1:0]        tw_k,
    output logic                    tw_last,
    output logic                    busy,
    output logic                    done,
    output logic                    err
);

    state_t                 state_q, state_d;
    logic [2:0]             stage_q, stage_d;
    logic [4:0]             b_q, b_d;
    logic                   issued_q, issued_d;
    logic                   tw_valid_q, tw_valid_d;
    logic signed [TW_W-1:0] tw_cos_q, tw_cos_d;
    logic signed [TW_W-1:0] tw_sin_q, tw_sin_d;
    logic [LOG2N-1:0]       tw_k_q, tw_k_d;
    logic                   tw_last_q, tw_last_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;

    logic [LOG2N-1:0]       k_mask;
    logic [LOG2N-1:0]       k_cur;
    logic signed [TW_W-1:0] lut_cos;
    logic signed [TW_W-1:0] lut_sin;
    logic                   start_ok;
    logic                   accept;
    logic                   load;

    assign k_mask = (6'd1 << stage_q) - 6'd1;
    assign k_cur  = ({1'b0, b_q} & k_mask) << (3'd5 - stage_q);

    tw_quarter_lut u_lut (
        .k     (k_cur),
        .cos_w (lut_cos),
        .sin_w (lut_sin)
    );

    // start is honoured only when fully idle, including the done cycle
    assign start_ok = start && (state_q == ST_IDLE) && !busy_q;
    assign accept   = tw_valid_q && out_ready;
    assign load     = (state_q == ST_RUN) && !issued_q && (!tw_valid_q || out_ready);

    always_comb begin
        state_d    = state_q;
        stage_d    = stage_q;
        b_d        = b_q;
        issued_d   = issued_q;
        tw_valid_d = tw_valid_q;
        tw_cos_d   = tw_cos_q;
        tw_sin_d   = tw_sin_q;
        tw_k_d     = tw_k_q;
        tw_last_d  = tw_last_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        if (state_q == ST_IDLE) begin
            if (start_ok) begin
                if (stage <= 3'd5) begin
                    state_d  = ST_RUN;
                    stage_d  = stage;
                    b_d      = '0;
                    issued_d = 1'b0;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else begin
            if (load) begin
                tw_valid_d = 1'b1;
                tw_cos_d   = lut_cos;
                tw_sin_d   = lut_sin;
                tw_k_d     = k_cur;
                tw_last_d  = (b_q == 5'd31);
                b_d        = b_q + 5'd1;
                issued_d   = (b_q == 5'd31);
            end else if (accept) begin
                tw_valid_d = 1'b0;
            end
            if (accept && tw_last_q) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
            end
        end

        busy_d = (state_d == ST_RUN) || done_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            stage_q    <= '0;
            b_q        <= '0;
            issued_q   <= 1'b0;
            tw_valid_q <= 1'b0;
            tw_cos_q   <= '0;
            tw_sin_q   <= '0;
            tw_k_q     <= '0;
            tw_last_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            stage_q    <= stage_d;
            b_q        <= b_d;
            issued_q   <= issued_d;
            tw_valid_q <= tw_valid_d;
            tw_cos_q   <= tw_cos_d;
            tw_sin_q   <= tw_sin_d;
            tw_k_q     <= tw_k_d;
            tw_last_q  <= tw_last_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign tw_valid = tw_valid_q;
    assign tw_cos   = tw_cos_q;
    assign tw_sin   = tw_sin_q;
    assign tw_k     = tw_k_q;
    assign tw_last  = tw_last_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_twiddle_streamer.sv
// Directed-vector bench for twiddle_streamer and its quarter-wave lookup.
module tb_twiddle_streamer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  stage;
    logic        out_ready;
    logic        tw_valid;
    logic [11:0] tw_cos;
    logic [11:0] tw_sin;
    logic [5:0]  tw_k;
    logic        tw_last;
    logic        busy;
    logic        done;
    logic        err;

    logic [5:0]  lut_k;
    logic [11:0] lut_cos;
    logic [11:0] lut_sin;

    int n_vec = 0;
    int n_err = 0;

    logic [11:0] ref_cos [64];
    logic [11:0] ref_sin [64];

    always #5 clk = ~clk;

    twiddle_streamer dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stage     (stage),
        .out_ready (out_ready),
        .tw_valid  (tw_valid),
        .tw_cos    (tw_cos),
        .tw_sin    (tw_sin),
        .tw_k      (tw_k),
        .tw_last   (tw_last),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    tw_quarter_lut u_lut (
        .k     (lut_k),
        .cos_w (lut_cos),
        .sin_w (lut_sin)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] enc(input bit neg, input int mag);
        logic [11:0] v;
        v = 12'(mag);
        if (!neg || mag == 0) return v;
        if (mag == 256) return 12'hF00;
        return ~v;
    endfunction

    task automatic build_ref();
        real th, c, s;
        for (int k = 0; k < 64; k++) begin
            th = 2.0 * 3.141592653589793 * real'(k) / 64.0;
            c  = $cos(th);
            s  = -$sin(th);
            ref_cos[k] = enc(c < 0.0, int'($floor(256.0 * ((c < 0.0) ? -c : c))));
            ref_sin[k] = enc(s < 0.0, int'($floor(256.0 * ((s < 0.0) ? -s : s))));
        end
    endtask

    task automatic check_idle_zero(input string tag);
        check_val({tag, "_valid"}, tw_valid, 0);
        check_val({tag, "_cos"},   tw_cos,   0);
        check_val({tag, "_sin"},   tw_sin,   0);
        check_val({tag, "_k"},     tw_k,     0);
        check_val({tag, "_last"},  tw_last,  0);
        check_val({tag, "_busy"},  busy,     0);
        check_val({tag, "_done"},  done,     0);
        check_val({tag, "_err"},   err,      0);
    endtask

    // One sweep: optional reset at beat abort_b, optional stray start at beat restart_b
    task automatic sweep(input logic [2:0] st, input int rdy_pct, input int abort_b,
                         input int restart_b, output int beats);
        int          b;
        bit          held;
        bit          fin;
        logic [31:0] snap;
        logic [5:0]  k;
        beats = 0;
        b     = 0;
        held  = 0;
        fin   = 0;
        snap  = '0;
        stage = st;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("busy_after_start", busy, 1);
        check_val("valid_lat1", tw_valid, 0);
        tick();
        check_val("valid_lat2", tw_valid, 1);
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            out_ready = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
            if (held) check_val("stall_hold", {tw_valid, tw_last, tw_k, tw_cos, tw_sin}, snap);
            if (rdy_pct >= 100) check_val("no_bubble", tw_valid, 1);
            if (tw_valid) begin
                k = 6'((b % (1 << st)) << (5 - st));
                check_val("beat_k",    tw_k,    k);
                check_val("beat_cos",  tw_cos,  ref_cos[k]);
                check_val("beat_sin",  tw_sin,  ref_sin[k]);
                check_val("beat_last", tw_last, (b == 31));
                if (b == abort_b) begin
                    rst = 1'b1;
                    tick();
                    rst = 1'b0;
                    check_idle_zero("abort");
                    tick();
                    check_val("abort_no_done", done, 0);
                    check_val("abort_valid", tw_valid, 0);
                    fin = 1;
                end
            end
            if (!fin) begin
                if (tw_valid && b == restart_b) begin
                    start = 1'b1;
                    stage = 3'd3;
                end
                held = tw_valid && !out_ready;
                snap = {tw_valid, tw_last, tw_k, tw_cos, tw_sin};
                if (tw_valid && out_ready) begin
                    beats++;
                    b++;
                end
                tick();
                start = 1'b0;
                if (b == 32) begin
                    check_val("done_pulse", done, 1);
                    check_val("done_busy", busy, 1);
                    check_val("done_valid", tw_valid, 0);
                    tick();
                    check_val("done_clear", done, 0);
                    check_val("busy_clear", busy, 0);
                    fin = 1;
                end
            end
        end
        check_val("sweep_finished", fin, 1);
    endtask

    initial begin
        int beats;
        rst       = 1'b1;
        start     = 1'b0;
        stage     = 3'd0;
        out_ready = 1'b0;
        lut_k     = 6'd0;
        build_ref();
        repeat (3) tick();
        check_idle_zero("reset");
        rst = 1'b0;
        tick();

        // Hand-computed lookup points, including the four quadrant boundaries
        lut_k = 6'd0;  #1; check_val("lut0_cos",  lut_cos, 12'h100); check_val("lut0_sin",  lut_sin, 12'h000);
        lut_k = 6'd1;  #1; check_val("lut1_cos",  lut_cos, 12'h0FE); check_val("lut1_sin",  lut_sin, 12'hFE6);
        lut_k = 6'd16; #1; check_val("lut16_cos", lut_cos, 12'h000); check_val("lut16_sin", lut_sin, 12'hF00);
        lut_k = 6'd17; #1; check_val("lut17_cos", lut_cos, 12'hFE6); check_val("lut17_sin", lut_sin, 12'hF01);
        lut_k = 6'd31; #1; check_val("lut31_cos", lut_cos, 12'hF01); check_val("lut31_sin", lut_sin, 12'hFE6);
        lut_k = 6'd32; #1; check_val("lut32_cos", lut_cos, 12'hF00); check_val("lut32_sin", lut_sin, 12'h000);
        lut_k = 6'd48; #1; check_val("lut48_cos", lut_cos, 12'h000); check_val("lut48_sin", lut_sin, 12'h100);
        for (int k = 0; k < 64; k++) begin
            lut_k = 6'(k);
            #1;
            check_val($sformatf("lut_cos_k%0d", k), lut_cos, ref_cos[k]);
            check_val($sformatf("lut_sin_k%0d", k), lut_sin, ref_sin[k]);
        end

        sweep(3'd0, 100, -1, -1, beats);
        check_val("s0_beats", beats, 32);
        sweep(3'd5, 100, -1, -1, beats);
        check_val("s5_beats", beats, 32);
        sweep(3'd1, 50, -1, -1, beats);
        check_val("s1_stall_beats", beats, 32);
        sweep(3'd2, 100, -1, 5, beats);
        check_val("s2_midstart_beats", beats, 32);
        tick();
        check_val("midstart_no_resweep", busy, 0);

        stage = 3'd6;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("err_pulse", err, 1);
        check_val("err_busy", busy, 0);
        check_val("err_valid", tw_valid, 0);
        tick();
        check_val("err_clear", err, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("err_no_beat", tw_valid, 0);
            check_val("err_no_busy", busy, 0);
        end

        sweep(3'd4, 100, 10, -1, beats);
        check_val("abort_beats", beats, 10);
        sweep(3'd3, 70, -1, -1, beats);
        check_val("after_abort_beats", beats, 32);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
